// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller in front of a word-wide memory,
// with alignment faults, lane extract/extend on loads and read-modify-write for sub-word stores.
module mem_access_ctrl #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t      state_q;
  logic        we_q, signed_q, ready_q, valid_q, fault_q, read_q, write_q;
  logic [1:0]  size_q, lo_q;
  logic [31:0] wdata_q, rdata_q, maddr_q, mwdata_q;
  logic        req_fault;
  logic [4:0]  sh;
  logic [31:0] lane_mask, shifted, load_d, merge_d;
  assign req_fault = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                     (req_size == 2'b10 & |req_addr[1:0]);
  // Big-endian lane k sits at bit offset 8*(3-k), which is 8*(k^3).
  always_comb begin
    sh = size_q == 2'b00 ? {lo_q ^ {2{BIG_ENDIAN}}, 3'b000} :
         size_q == 2'b01 ? {lo_q[1] ^ BIG_ENDIAN, 4'b0000} : 5'd0;
    lane_mask = (size_q == 2'b00 ? 32'h0000_00FF : size_q == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
    shifted = mem_rdata >> sh;
    load_d = size_q == 2'b00 ? {{24{signed_q & shifted[7]}}, shifted[7:0]} :
             size_q == 2'b01 ? {{16{signed_q & shifted[15]}}, shifted[15:0]} : mem_rdata;
    merge_d = (mem_rdata & ~lane_mask) | ((wdata_q << sh) & lane_mask);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      lo_q     <= 2'b00;
      wdata_q  <= 32'h0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE:
          if (req_valid && ready_q) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            lo_q     <= req_addr[1:0];
            wdata_q  <= req_wdata;
            ready_q  <= 1'b0;
            if (req_fault) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              maddr_q <= {req_addr[31:2], 2'b00};
              if (req_we && req_size == 2'b10) begin
                state_q  <= WR;
                write_q  <= 1'b1;
                mwdata_q <= req_wdata;
              end else begin
                state_q <= RD;
                read_q  <= 1'b1;
              end
            end
          end else ready_q <= 1'b1;
        RD: begin
          read_q <= 1'b0;
          if (we_q) begin
            state_q  <= WR;
            write_q  <= 1'b1;
            mwdata_q <= merge_d;
          end else begin
            state_q <= RESP;
            valid_q <= 1'b1;
            rdata_q <= load_d;
            maddr_q <= 32'h0;
          end
        end
        WR: begin
          state_q  <= RESP;
          write_q  <= 1'b0;
          maddr_q  <= 32'h0;
          mwdata_q <= 32'h0;
          valid_q  <= 1'b1;
        end
        RESP:
          if (resp_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b1;
          end
      endcase
    end
  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_fault = fault_q;
  assign resp_rdata = rdata_q;
  assign mem_read   = read_q;
  assign mem_write  = write_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
endmodule
